// File: rtl/spi_baud_gen_param.sv
// rtl/spi_baud_gen_param.sv - SPI SCLK generator with sample/shift strobes, pre-strobes and per-frame edge counter
// Divisor (sppr+1)*2^(spr+1) and frame length are latched on activation; sclk = cpol ^ phase register.
module spi_baud_gen_param #(
   parameter int SPPR_W  = 3,
   parameter int SPR_W   = 3,
   parameter int CNT_W   = 12,
   parameter int FRAME_W = 4
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic [1:0]         spi_mode,
   input  logic               spiswai,
   input  logic [SPPR_W-1:0]  sppr,
   input  logic [SPR_W-1:0]   spr,
   input  logic               cpol,
   input  logic               cpha,
   input  logic               ss,
   input  logic [FRAME_W-1:0] frame_len,
   output logic               sclk,
   output logic               sample_stb,
   output logic               shift_stb,
   output logic               pre_sample_stb,
   output logic               pre_shift_stb,
   output logic [FRAME_W-1:0] bit_idx,
   output logic               busy,
   output logic               frame_done,
   output logic               frame_abort,
   output logic [CNT_W-1:0]   baudratedivisor
);

   localparam int EW = FRAME_W + 1;

   generate
      if (CNT_W < SPPR_W + (1 << SPR_W) + 1) begin : g_cnt_w_check
         $error("CNT_W cannot hold the largest divisor");
      end
   endgenerate

   logic [CNT_W-1:0] pre_div;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] div_eff;
   logic [CNT_W-1:0] count;
   logic [EW-1:0]    last_live;
   logic [EW-1:0]    last_q;
   logic [EW-1:0]    last_eff;
   logic [EW-1:0]    edge_cnt;
   logic             phase;
   logic             active;
   logic             first;
   logic             edge_w;
   logic             pre_w;
   logic             is_sample;

   assign pre_div         = CNT_W'(sppr) + CNT_W'(1);
   assign baudratedivisor = pre_div << ({1'b0, spr} + (SPR_W + 1)'(1));

   assign active = ~ss & ~spiswai & ~spi_mode[1];
   assign first  = active & ~busy;

   // frame_len==0 wraps to all ones, which is exactly 2*2^FRAME_W-1
   assign last_live = {frame_len, 1'b0} - EW'(1);

   // The activation cycle already runs on the freshly selected config
   assign div_eff  = first ? baudratedivisor : div_q;
   assign last_eff = first ? last_live : last_q;

   assign edge_w    = active & (count == div_eff - CNT_W'(1));
   assign pre_w     = active & (count == div_eff - CNT_W'(2));
   // Even edge_cnt is the leading edge; it samples when cpha=0
   assign is_sample = (edge_cnt[0] == cpha);

   assign sclk    = cpol ^ phase;
   assign bit_idx = edge_cnt[EW-1:1];

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         busy           <= 1'b0;
         div_q          <= '0;
         last_q         <= '0;
         count          <= '0;
         edge_cnt       <= '0;
         phase          <= 1'b0;
         sample_stb     <= 1'b0;
         shift_stb      <= 1'b0;
         pre_sample_stb <= 1'b0;
         pre_shift_stb  <= 1'b0;
         frame_done     <= 1'b0;
         frame_abort    <= 1'b0;
      end else begin
         busy           <= active;
         sample_stb     <= edge_w & is_sample;
         shift_stb      <= edge_w & ~is_sample;
         pre_sample_stb <= pre_w & is_sample;
         pre_shift_stb  <= pre_w & ~is_sample;
         frame_done     <= edge_w & (edge_cnt == last_eff);
         frame_abort    <= ~active & (edge_cnt != '0);
         if (first) begin
            div_q  <= baudratedivisor;
            last_q <= last_live;
         end
         if (!active) begin
            count    <= '0;
            edge_cnt <= '0;
            phase    <= 1'b0;
         end else if (edge_w) begin
            count    <= '0;
            phase    <= ~phase;
            edge_cnt <= (edge_cnt == last_eff) ? '0 : edge_cnt + EW'(1);
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/spi_baud_gen_param.md
Name: spi_baud_gen_param

Overview:
Parametrised next-generation SPI clock generator for the APB SPI master core. It derives SCLK from PCLK using the SPPR/SPR divisor. It emits sample/shift strobes and early-warning strobes for all four CPOL/CPHA modes, and adds a per-frame edge/bit counter with frame-done and abort pulses. It sits between the APB register block and the shift register/controller FSM.

Parameters:
SPPR_W, 3, width of sppr prescaler field
SPR_W, 3, width of spr shift field
CNT_W, 12, divisor/counter width; must hold (2^SPPR_W)*2^(2^SPR_W); elaboration error otherwise
FRAME_W, 4, width of frame_len; max frame 2^FRAME_W bits

Ports:
PCLK  in  1  system clock
PRESETn  in  1  asynchronous active-low reset
spi_mode  in  2  00 run, 01 wait, 1x stop
spiswai  in  1  halt in wait mode
sppr  in  SPPR_W  prescaler
spr  in  SPR_W  divisor exponent
cpol  in  1  idle SCLK level
cpha  in  1  clock phase
ss  in  1  slave select, active low
frame_len  in  FRAME_W  bits per frame; 0 means 2^FRAME_W
sclk  out  1  SPI clock
sample_stb  out  1  one-cycle pulse on sample edge
shift_stb  out  1  one-cycle pulse on shift edge
pre_sample_stb  out  1  pulse one PCLK before sample_stb
pre_shift_stb  out  1  pulse one PCLK before shift_stb
bit_idx  out  FRAME_W  current bit index in frame
busy  out  1  generator active
frame_done  out  1  pulse on final edge of frame
frame_abort  out  1  pulse when deactivated mid-frame
baudratedivisor  out  CNT_W  live divisor (sppr+1)*2^(spr+1)

Behaviour:
- Reset: sclk=cpol, all strobes/pulses 0, bit_idx=0, busy=0, internal count/edge_cnt/div_q=0.
- active = ~ss & ~spiswai & (spi_mode==00 | spi_mode==01). Combinational, same as the legacy generator.
- baudratedivisor: combinational, computed at CNT_W width, no truncation within legal params. Minimum value 2.
- div_q latch: loaded from baudratedivisor on the first active cycle (idle->active). Config changes while active are ignored until next activation.
- count: 0..div_q-1, wraps. Held at 0 when inactive.
- edge: active & count==div_q-1. On edge, sclk toggles (registered). Half-period = div_q PCLK cycles.
- Edge classification: leading = first toggle away from cpol. With cpha=0, leading=sample and trailing=shift. With cpha=1, leading=shift and trailing=sample.
- Strobe timing: sample_stb/shift_stb are registered, high exactly in the first cycle sclk shows its new level.
- Pre-strobes: pre_* fire on count==div_q-2 of the cycle preceding the corresponding edge, giving one cycle of lead. With div_q=2 this is count==0.
- edge_cnt: width FRAME_W+1, counts edges 0..2*N-1, where N is frame_len (0→2^FRAME_W), sampled at activation.
- bit_idx = edge_cnt>>1, registered with sclk.
- frame_done: pulses with the strobe of edge 2N-1. edge_cnt wraps to 0. If still active, the next frame starts seamlessly with no idle gap; sclk is at cpol after edge 2N.
- Deactivation: when active drops, the next cycle has sclk=cpol, count=0, edge_cnt=0, bit_idx=0, no strobes. frame_abort pulses 1 cycle if edge_cnt!=0 at that point. No abort if the frame has just completed.
- Edge and deactivation in the same cycle: deactivation wins; no strobe, sclk goes to cpol.
- spi_mode 1x or ss high: behaves as inactive.
- busy = registered active.
- Reset mid-frame: immediate return to reset values, no pulses.

Test Plan:
- Mode 0: sppr=2, spr=1 (div 12), frame_len=8, ss low at cycle 0 → sclk first rises at cycle 12, period 24. 8 sample_stb on rising edges; frame_done at cycle 192; sclk low after.
- Mode 3 (cpol=1, cpha=1): div 2, frame_len=4 → sclk idles 1. shift_stb on falling, sample_stb on rising edges; pre_* exactly 1 cycle ahead; frame_done at cycle 16.
- Continuous: ss held low over 3 frames of frame_len=0 (FRAME_W=4) → 3 frame_done pulses 512 cycles apart (div 16: sppr=1, spr=2); no sclk gap.
- Abort: ss high after 5 edges → next cycle sclk=cpol, bit_idx=0, frame_abort=1 for one cycle; no strobes afterward.
- Config change: change spr while active → period unchanged until ss high/low cycle, then new period applies. baudratedivisor output updates immediately.
- Wait mode: spi_mode=01, spiswai=1 → busy=0, sclk=cpol. Set spiswai=0 → generation starts, first edge after div_q cycles.
